// File: rtl/delay_stream_pkg.sv
// Shared types for the delay_stream_out prime-then-stream buffer.
package delay_stream_pkg;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module sdp_ram #(
    parameter int ENTRIES = 32,
    parameter int WIDTH   = 16,
    localparam int AW     = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // Read data holds while re_i is low, so an unconsumed word stays put.
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/delay_stream_out.sv
// Delay buffer: collects DEPTH samples before streaming them out through a
// one-word registered output with valid/ready handshake.
module delay_stream_out
    import delay_stream_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 16,
    localparam int CAP   = 2 * DEPTH,
    localparam int CW    = $clog2(CAP) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [CW-1:0]    fill,
    output logic             overflow,
    output logic             underflow
);

    localparam int AW = $clog2(CAP);
    localparam logic [CW-1:0] CAP_C   = CW'(CAP);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    state_e           state_q, state_d;
    logic [AW-1:0]    wrPtr_q, wrPtr_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    fill_q, fill_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             doutValid_q, doutValid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wrAcc, pop, load;
    logic [WIDTH-1:0] ramRdata;

    // pend_q marks a popped word waiting in the RAM read register. Popping only
    // when the output register is free or draining guarantees pend_q is never
    // overwritten: if it is set, the same condition also moves it out.
    assign wrAcc = en && !flush && (fill_q < CAP_C);
    assign pop   = !flush && (state_q == RUN) && (fill_q != '0) && (!doutValid_q || dout_ready);
    assign load  = !flush && pend_q && (!doutValid_q || dout_ready);

    sdp_ram #(
        .ENTRIES (CAP),
        .WIDTH   (WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wrAcc),
        .waddr_i (wrPtr_q),
        .wdata_i (din),
        .re_i    (pop),
        .raddr_i (rdPtr_q),
        .rdata_o (ramRdata)
    );

    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        fill_d      = fill_q;
        pend_d      = pend_q;
        dout_d      = dout_q;
        doutValid_d = doutValid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (en && !flush && (fill_q == CAP_C)) overflow_d = 1'b1;
        if (wrAcc) wrPtr_d = wrPtr_q + AW'(1);
        if (pop)   rdPtr_d = rdPtr_q + AW'(1);

        if (wrAcc && !pop)      fill_d = fill_q + CW'(1);
        else if (!wrAcc && pop) fill_d = fill_q - CW'(1);

        if (pop)       pend_d = 1'b1;
        else if (load) pend_d = 1'b0;

        if (load) begin
            dout_d      = ramRdata;
            doutValid_d = 1'b1;
        end else if (dout_ready) begin
            doutValid_d = 1'b0;
        end

        case (state_q)
            PRIME: if (fill_d == DEPTH_C) state_d = RUN;
            RUN: begin
                if ((fill_d == '0) && !wrAcc) begin
                    state_d     = PRIME;
                    underflow_d = 1'b1;
                end
            end
            default: state_d = PRIME;
        endcase

        // Flush keeps the sticky flags so the consumer can still see them.
        if (flush) begin
            state_d     = PRIME;
            wrPtr_d     = '0;
            rdPtr_d     = '0;
            fill_d      = '0;
            pend_d      = 1'b0;
            doutValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= PRIME;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;
    assign fill       = fill_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
